// File: rtl/mul_pkg.sv
// Shared op codes, FSM encoding and op-decode helpers for the iterative multiplier.
package mul_pkg;

  localparam logic [2:0] MUL_OP_MULT  = 3'b000;
  localparam logic [2:0] MUL_OP_MULTU = 3'b001;
  localparam logic [2:0] MUL_OP_MADD  = 3'b010;
  localparam logic [2:0] MUL_OP_MADDU = 3'b011;
  localparam logic [2:0] MUL_OP_MSUB  = 3'b100;
  localparam logic [2:0] MUL_OP_MSUBU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_valid_op(input logic [2:0] op);
    return op[2:1] != 2'b11;
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == MUL_OP_MULT) || (op == MUL_OP_MADD) || (op == MUL_OP_MSUB);
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op == MUL_OP_MADD) || (op == MUL_OP_MADDU);
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return (op == MUL_OP_MSUB) || (op == MUL_OP_MSUBU);
  endfunction

endpackage

// File: rtl/mul_pp_step.sv
// One radix-2^BPC partial-product term: mcand * slice, aligned to its digit position.
module mul_pp_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 4,
  parameter int SH_W  = 5
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [BPC-1:0]     slice,
  input  logic [SH_W-1:0]    shamt,
  output logic [2*WIDTH-1:0] addend
);

  logic [2*WIDTH-1:0] term;

  assign term   = {{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-BPC){1'b0}}, slice};
  assign addend = term << shamt;

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative sign-magnitude multiply / multiply-accumulate unit with start/busy/done handshake.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result_o,
  output logic               stall_mul
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           op_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q, mplier_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   pp_q;
  logic [2*WIDTH-1:0]   result_q;

  logic signed [WIDTH-1:0] opa_s, opb_s;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 accept, last_iter;
  logic [SH_W-1:0]      shamt;
  logic [2*WIDTH-1:0]   addend, prod_fix, res_fix;

  assign opa_s  = opa;
  assign opb_s  = opb;
  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign a_mag  = (is_signed(op) && opa_s < 0) ? $unsigned(-opa_s) : opa;
  assign b_mag  = (is_signed(op) && opb_s < 0) ? $unsigned(-opb_s) : opb;
  assign accept = (state_q == S_IDLE) && start && is_valid_op(op) && !flush;
  assign last_iter = (cnt_q == CNT_W'(N - 1));
  assign shamt  = SH_W'(cnt_q) * SH_W'(BPC);

  mul_pp_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC),
    .SH_W  (SH_W)
  ) u_pp_step (
    .mcand  (mcand_q),
    .slice  (mplier_q[BPC-1:0]),
    .shamt  (shamt),
    .addend (addend)
  );

  assign prod_fix = neg_q ? (~pp_q + 1'b1) : pp_q;
  assign res_fix  = is_sub(op_q) ? (acc_q - prod_fix) :
                    is_acc(op_q) ? (acc_q + prod_fix) : prod_fix;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start && is_valid_op(op)) state_d = S_CALC;
      S_CALC: if (last_iter) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Operand capture on accept, digit accumulation in CALC, sign fix-up and accumulate in FIX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      pp_q     <= '0;
      result_q <= '0;
    end else if (!flush) begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          op_q     <= op;
          acc_q    <= acc_i;
          mcand_q  <= a_mag;
          mplier_q <= b_mag;
          neg_q    <= is_signed(op) & (opa[WIDTH-1] ^ opb[WIDTH-1]);
          pp_q     <= '0;
          cnt_q    <= '0;
        end
        S_CALC: begin
          pp_q     <= pp_q + addend;
          mplier_q <= mplier_q >> BPC;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        S_FIX:   result_q <= res_fix;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign result_o  = result_q;
  assign stall_mul = start & is_valid_op(op) & ~done;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit: directed handshake cases plus a randomised sweep against an arithmetic model.
module tb_mul_iter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opa = '0, opb = '0;
  logic [63:0] acc_i = '0;
  logic        busy, done, stall_mul;
  logic [63:0] result_o;

  logic        h_flush = 1'b0;
  logic        h_start = 1'b0;
  logic [2:0]  h_op = 3'd0;
  logic [15:0] h_opa = '0, h_opb = '0;
  logic [31:0] h_acc = '0;
  logic        h_busy, h_done, h_stall;
  logic [31:0] h_res;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] last_exp = '0;

  always #5 clk = ~clk;

  mul_iter_unit #(.WIDTH(32), .BPC(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .opa(opa), .opb(opb), .acc_i(acc_i), .busy(busy), .done(done),
    .result_o(result_o), .stall_mul(stall_mul)
  );

  mul_iter_unit #(.WIDTH(16), .BPC(2)) dut16 (
    .clk(clk), .rst(rst), .flush(h_flush), .start(h_start), .op(h_op),
    .opa(h_opa), .opb(h_opb), .acc_i(h_acc), .busy(h_busy), .done(h_done),
    .result_o(h_res), .stall_mul(h_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Plain full-width product from the op table, truncated to 2*w bits.
  function automatic logic [63:0] ref_model(input int w, input logic [2:0] o,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] acc);
    logic signed [63:0] sa, sb, p;
    logic [63:0] mask, r;
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    if (o == 3'd0 || o == 3'd2 || o == 3'd4) begin
      sa = a << (64 - w);
      sa = sa >>> (64 - w);
      sb = b << (64 - w);
      sb = sb >>> (64 - w);
    end else begin
      sa = a & ((64'd1 << w) - 64'd1);
      sb = b & ((64'd1 << w) - 64'd1);
    end
    p = sa * sb;
    case (o)
      3'd2, 3'd3: r = acc + p;
      3'd4, 3'd5: r = acc - p;
      default:    r = p;
    endcase
    return r & mask;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] acc, input string tag);
    logic [63:0] exp;
    int lat, stl;
    exp = ref_model(32, o, {32'd0, a}, {32'd0, b}, acc);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; acc_i = acc;
    #1 check({tag, "_stall_req"}, 64'(stall_mul), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    // Operands are scrambled while the op is in flight; the unit must not re-sample them.
    opa = $urandom; opb = $urandom; acc_i = {$urandom, $urandom};
    lat = 0; stl = 0;
    while (!done && lat < 20) begin
      if (stall_mul) stl++;
      @(posedge clk);
      #1 lat++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_stall_cycles"}, 64'(stl), 64'd9);
    check({tag, "_res"}, result_o, exp);
    last_exp = exp;
    @(posedge clk);
    #1 check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic run16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] acc, input string tag);
    logic [63:0] exp;
    int lat;
    exp = ref_model(16, o, {48'd0, a}, {48'd0, b}, {32'd0, acc});
    @(posedge clk);
    @(negedge clk);
    h_start = 1'b1; h_op = o; h_opa = a; h_opb = b; h_acc = acc;
    @(posedge clk);
    #1 lat = 0;
    while (!h_done && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    h_start = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_res"}, {32'd0, h_res}, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_res", result_o, 64'd0);
    check("rst_res16", {32'd0, h_res}, 64'd0);
    @(negedge clk) rst = 1'b1;

    run32(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 64'd0, "mult_neg");
    run32(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 64'd0, "multu");
    run32(3'b000, 32'h8000_0000, 32'h8000_0000, 64'd0, "mult_min");
    run32(3'b010, 32'hFFFF_FFFD, 32'h0000_0002, 64'd5, "madd");
    run32(3'b101, 32'h0000_0001, 32'h0000_0001, 64'd0, "msubu");

    // Flush in the fourth CALC cycle.
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b000; opa = 32'd7; opb = 32'd9; acc_i = '0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    flush = 1'b0;
    seen = 0;
    repeat (12) begin
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_res_kept", result_o, last_exp);
    run32(3'b000, 32'd3, 32'd4, 64'd0, "after_flush");

    // flush together with start in IDLE must not accept.
    @(negedge clk);
    start = 1'b1; op = 3'b001; opa = 32'd5; opb = 32'd5; flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_start_busy", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = 3'b001; opa = 32'd5; opb = 32'd6;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_res", result_o, 64'd0);
    start = 1'b0;
    @(negedge clk) rst = 1'b1;
    last_exp = '0;

    // Reserved op is ignored.
    @(negedge clk);
    start = 1'b1; op = 3'b110; opa = 32'd2; opb = 32'd3;
    #1 check("rsv_stall", 64'(stall_mul), 64'd0);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (busy || done) seen++;
    end
    check("rsv_no_busy", 64'(seen), 64'd0);
    check("rsv_res_kept", result_o, last_exp);
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      run32(3'($urandom_range(0, 5)), pick32(), pick32(), {$urandom, $urandom}, "rand32");
    end

    run16(3'b000, 16'h8000, 16'h7FFF, 32'd0, "w16_mult");
    for (int i = 0; i < 12; i++) begin
      run16(3'($urandom_range(0, 5)), 16'($urandom), 16'($urandom), $urandom, "rand16");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
